counter_arbiter: RTL
====================

Name: counter_arbiter

Overview:
Sequencer and arbiter that shares one up/down saturating counter (load, enable, direction, WIDTH-bit value) between two requesters. Each request is a (start, target) pair. The block grants one requester round-robin, loads the counter with start and counts toward target one step per cycle. It stops the counter exactly on target, then pulses done to the owner. It sits between the requesters and the counter instance and is the only driver of the counter's control inputs.

Parameters:
WIDTH, 4, counter/value width in bits; start, target and ctr_value all use this width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  2  req[i]=1: requester i has a pending command
start0  input  WIDTH  requester 0 start value
target0  input  WIDTH  requester 0 target value
start1  input  WIDTH  requester 1 start value
target1  input  WIDTH  requester 1 target value
ack  output  2  one-cycle pulse; request i accepted, start/target latched
done  output  2  one-cycle pulse; owner's count reached target
busy  output  1  high in every state except IDLE
owner  output  1  index of current/last granted requester
ctr_data  output  WIDTH  counter load value
ctr_load  output  1  counter load strobe
ctr_en  output  1  counter count enable
ctr_up  output  1  count direction, 1=up
ctr_value  input  WIDTH  counter current value

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state=IDLE; ack=0, done=0, busy=0, owner=0; ctr_data=0, ctr_load=0, ctr_en=0, ctr_up=0; round-robin pointer set so req[0] wins the first tie. Reset mid-operation aborts the command with no done pulse. The counter keeps its value.
- Request rules: a requester holds req[i] and keeps start/target stable until ack[i]. It drops req[i] in the cycle after ack[i]. Requests are ignored while busy=1.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: if any req bit is set, grant:
  - only one set: grant that one;
  - both set: grant the one not granted last.
  - In that cycle: ack[g]=1; latch start, target and dir=(target>start); owner<=g; next state LOAD. busy rises the following cycle.
- LOAD (1 cycle): ctr_load=1, ctr_en=1, ctr_data=latched start, ctr_up=dir. Next state RUN.
- RUN:
  - ctr_up=dir.
  - ctr_en = (ctr_value != target), combinational, so the counter stops exactly on target.
  - When ctr_value==target, next state DONE.
- DONE (1 cycle): done[owner]=1, ctr_en=0. Next state IDLE. A new grant is possible in the following IDLE cycle.
- Latency: N=|target−start|. ack in cycle 0, LOAD cycle 1, RUN cycles 2..N+2, done in cycle N+3.
- start==target: RUN lasts one cycle with ctr_en=0; done 3 cycles after ack.
- Comparison is unsigned WIDTH-bit. Counting never crosses 0 or 2^WIDTH−1, so counter saturation is never reached. No wrap-around.
- ctr_load and ctr_en are 0 outside LOAD/RUN. ctr_data holds the last latched start.

Test Plan:
1. Reset, then req=01, start0=3, target0=7 -> ack=01 at cycle 0; ctr_load at cycle 1 with data 3; ctr_value steps 4,5,6,7; ctr_en low when value=7; done=01 at cycle 7.
2. req=10, start1=12, target1=2 -> ctr_up=0; 10 decrements; done=10 at cycle 13; busy low the cycle after done.
3. Both req=11 from reset, each start=5/target=5 -> requester 0 acked first, done=01 at cycle 3; requester 1 acked in the next IDLE cycle; then a new 11 tie grants requester 0 again.
4. start=0→target=15 up and start=15→target=0 down -> exactly 15 enabled steps each; no wrap; ctr_value ends at 15 and 0 respectively.
5. rst asserted during RUN of a 0→10 command at ctr_value=4 -> next cycle IDLE, all outputs 0, no done pulse; a subsequent request is accepted normally.
6. req[1] raised while busy serving requester 0 -> no ack until requester 0's done cycle has passed; then ack=10 in the first IDLE cycle.

Source files
------------

// File: rtl/counter_arbiter_if.sv
// -----------------------------------------------------------------------------
// counter_arbiter_if
// Groups the requester handshake (req/start/target/ack/done/busy/owner) and
// the shared-counter control bus (ctr_data/ctr_load/ctr_en/ctr_up/ctr_value)
// used by counter_arbiter.
//   slave  : the arbiter side (consumes requests and ctr_value, drives the rest)
//   master : the environment side (requesters plus the counter instance)
// -----------------------------------------------------------------------------
interface counter_arbiter_if #(
   parameter int WIDTH = 4
);
   logic [1:0]       req;
   logic [WIDTH-1:0] start0;
   logic [WIDTH-1:0] target0;
   logic [WIDTH-1:0] start1;
   logic [WIDTH-1:0] target1;
   logic [1:0]       ack;
   logic [1:0]       done;
   logic             busy;
   logic             owner;
   logic [WIDTH-1:0] ctr_data;
   logic             ctr_load;
   logic             ctr_en;
   logic             ctr_up;
   logic [WIDTH-1:0] ctr_value;

   modport slave (
      input  req, start0, target0, start1, target1, ctr_value,
      output ack, done, busy, owner, ctr_data, ctr_load, ctr_en, ctr_up
   );

   modport master (
      output req, start0, target0, start1, target1, ctr_value,
      input  ack, done, busy, owner, ctr_data, ctr_load, ctr_en, ctr_up
   );
endinterface

// File: rtl/counter_arbiter.sv
// -----------------------------------------------------------------------------
// counter_arbiter
// Shares one up/down counter between two requesters. A request (start, target)
// is granted round-robin, the counter is loaded with start and then stepped one
// value per cycle toward target, stopping exactly on target; the owner then
// receives a one-cycle done pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (aborts any command, no done)
//   bus  - counter_arbiter_if.slave: req/start/target in, ack/done/busy/owner
//          out, counter control (ctr_data/ctr_load/ctr_en/ctr_up) out and
//          ctr_value in
// -----------------------------------------------------------------------------
module counter_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   counter_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             dir_q, dir_d;
   logic             owner_q, owner_d;
   // Last granted requester; reset to 1 so requester 0 wins the first tie.
   logic             last_q, last_d;

   logic             grant_s;
   logic [1:0]       ack_s;
   logic             ctr_en_s;
   logic [WIDTH-1:0] sel_start_s;
   logic [WIDTH-1:0] sel_target_s;

   // State and command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         start_q  <= {WIDTH{1'b0}};
         target_q <= {WIDTH{1'b0}};
         dir_q    <= 1'b0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         target_q <= target_d;
         dir_q    <= dir_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
      end
   end

   // Round-robin pick among the pending requests.
   always_comb begin
      grant_s = 1'b0;
      case (bus.req)
         2'b01:   grant_s = 1'b0;
         2'b10:   grant_s = 1'b1;
         2'b11:   grant_s = ~last_q;
         default: grant_s = 1'b0;
      endcase
      if (grant_s) begin
         sel_start_s  = bus.start1;
         sel_target_s = bus.target1;
      end else begin
         sel_start_s  = bus.start0;
         sel_target_s = bus.target0;
      end
   end

   // Next-state logic, command latch and the per-state counter controls.
   always_comb begin
      state_d  = state_q;
      start_d  = start_q;
      target_d = target_q;
      dir_d    = dir_q;
      owner_d  = owner_q;
      last_d   = last_q;
      ack_s    = 2'b00;
      ctr_en_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req != 2'b00) begin
               ack_s    = grant_s ? 2'b10 : 2'b01;
               start_d  = sel_start_s;
               target_d = sel_target_s;
               dir_d    = (sel_target_s > sel_start_s);
               owner_d  = grant_s;
               last_d   = grant_s;
               state_d  = ST_LOAD;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_LOAD: begin
            ctr_en_s = 1'b1;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            // Enable drops in the same cycle the value arrives on target, so
            // the counter never steps past it.
            ctr_en_s = (bus.ctr_value != target_q);
            if (bus.ctr_value == target_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.ack      = ack_s;
   assign bus.done     = (state_q == ST_DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.owner    = owner_q;
   assign bus.ctr_data = start_q;
   assign bus.ctr_load = (state_q == ST_LOAD);
   assign bus.ctr_en   = ctr_en_s;
   assign bus.ctr_up   = ((state_q == ST_LOAD) || (state_q == ST_RUN)) ? dir_q : 1'b0;

endmodule
